// File: rtl/regfile_pkg.sv
// Shared constants, index type and index-validity helper for the register file slice.
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_REG_COUNT  = 16;
   localparam int DEF_ADDR_WIDTH = 4;

   typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

   localparam int unsigned R_ZERO = 0;

   // An index names real storage only if it exists and is not the hardwired-zero slot.
   function automatic logic idx_valid(input int unsigned idx,
                                      input int unsigned reg_count,
                                      input logic        r0_zero);
      return (idx < reg_count) && !(r0_zero && (idx == R_ZERO));
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking issued-but-not-written-back producers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_COUNT  = DEF_REG_COUNT,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit R0_ZERO    = 1'b1
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  flush,
   input  logic                  sb_set,
   input  logic [ADDR_WIDTH-1:0] sb_addr,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   input  logic                  mask_a,
   input  logic                  mask_b,
   output logic                  busy_a,
   output logic                  busy_b
);

   logic [REG_COUNT-1:0] busy;
   logic                 set_ok;

   assign set_ok = sb_set && idx_valid(32'(sb_addr), REG_COUNT, R0_ZERO);

   // flush beats set beats writeback; set and writeback on the same index leaves the bit set
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         busy <= '0;
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (set_ok && (sb_addr == ADDR_WIDTH'(i)))
               busy[i] <= 1'b1;
            else if (wb_en && (wb_addr == ADDR_WIDTH'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      busy_a = 1'b0;
      busy_b = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rd_addr_a == ADDR_WIDTH'(i)) busy_a = busy[i];
         if (rd_addr_b == ADDR_WIDTH'(i)) busy_b = busy[i];
      end
      if (mask_a) busy_a = 1'b0;
      if (mask_b) busy_b = 1'b0;
   end

endmodule

// File: rtl/register_file.sv
// Multi-entry register file: two combinational read ports, one clocked write port,
// optional hardwired R0, write-to-read bypass and a busy scoreboard.
module register_file
   import regfile_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                    REG_COUNT  = DEF_REG_COUNT,
   parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter bit                    R0_ZERO    = 1'b1,
   parameter bit                    BYPASS     = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   input  logic                  sb_set,
   input  logic [ADDR_WIDTH-1:0] sb_addr,
   input  logic                  flush,
   output logic                  busy_a,
   output logic                  busy_b
);

   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
   logic                                 wr_ok;
   logic                                 byp_a;
   logic                                 byp_b;

   assign wr_ok = wr_en && idx_valid(32'(wr_addr), REG_COUNT, R0_ZERO);
   assign byp_a = BYPASS && wr_ok && (wr_addr == rd_addr_a);
   assign byp_b = BYPASS && wr_ok && (wr_addr == rd_addr_b);

   // R0 is reset to zero and never selected by wr_ok, so it stays zero.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < REG_COUNT; i++)
            regs[i] <= (R0_ZERO && (i == R_ZERO)) ? '0 : INIT;
      end else begin
         for (int i = 0; i < REG_COUNT; i++)
            if (wr_ok && (wr_addr == ADDR_WIDTH'(i)))
               regs[i] <= wr_data;
      end
   end

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rd_addr_a == ADDR_WIDTH'(i)) rd_data_a = regs[i];
         if (rd_addr_b == ADDR_WIDTH'(i)) rd_data_b = regs[i];
      end
      if (R0_ZERO && (rd_addr_a == ADDR_WIDTH'(R_ZERO))) rd_data_a = '0;
      if (R0_ZERO && (rd_addr_b == ADDR_WIDTH'(R_ZERO))) rd_data_b = '0;
      if (byp_a) rd_data_a = wr_data;
      if (byp_b) rd_data_b = wr_data;
   end

   // Forwarded reads must not stall on the producer being retired this very cycle.
   regfile_scoreboard #(
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH),
      .R0_ZERO    (R0_ZERO)
   ) u_sb (
      .clock     (clock),
      .clear     (clear),
      .flush     (flush),
      .sb_set    (sb_set),
      .sb_addr   (sb_addr),
      .wb_en     (wr_ok),
      .wb_addr   (wr_addr),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .mask_a    (byp_a),
      .mask_b    (byp_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b)
   );

endmodule
